vid_timing_gen: RTL and testbench

VID_TIMING_GEN -- requirements
Module: vid_timing_gen

---
 rtl/vid_pkg.sv | 14 +
 rtl/vid_pattern_gen.sv | 33 +++
 rtl/vid_timing_gen.sv | 110 +++++++++++
 tb/tb_vid_timing_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// vid_pkg: shared types and bar colours for the video timing generator
package vid_pkg;

    typedef enum logic [1:0] {PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_WHITE} pattern_e;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    // Index 0 is the leftmost bar
    localparam logic [7:0][23:0] BAR_COLORS = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

endpackage

// File: rtl/vid_pattern_gen.sv
// vid_pattern_gen: combinational test-pattern pixel source, black outside the active area
module vid_pattern_gen
    import vid_pkg::*;
#(
    parameter int COLORDEPTH = 8,
    parameter int HW         = 10,
    parameter int VW         = 10,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480
) (
    input  logic [1:0]              pattern,
    input  logic [HW-1:0]           hcnt,
    input  logic [VW-1:0]           vcnt,
    input  logic [2:0]              bar_idx,
    output logic [3*COLORDEPTH-1:0] rgb
);

    logic                  dv;
    logic [COLORDEPTH-1:0] grey;

    assign dv   = hcnt < HW'(H_ACTIVE) && vcnt < VW'(V_ACTIVE);
    assign grey = COLORDEPTH'(hcnt);

    // Bar channels are either off or full scale, so one bit per channel suffices
    always_comb
        rgb = !dv                      ? '0 :
              pattern == 2'(PAT_BARS)  ? {{COLORDEPTH{BAR_COLORS[bar_idx][23]}},
                                          {COLORDEPTH{BAR_COLORS[bar_idx][15]}},
                                          {COLORDEPTH{BAR_COLORS[bar_idx][7]}}} :
              pattern == 2'(PAT_RAMP)  ? {3{grey}} :
              pattern == 2'(PAT_CHECK) ? {3*COLORDEPTH{~(hcnt[3] ^ vcnt[3])}} : '1;

endmodule

// File: rtl/vid_timing_gen.sv
// vid_timing_gen: raster timing generator with registered sync/valid outputs and test patterns
module vid_timing_gen
    import vid_pkg::*;
#(
    parameter int COLORDEPTH = 8,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic [1:0]              pattern_sel_i,
    output logic [3*COLORDEPTH-1:0] rgb_o,
    output logic                    dv_o,
    output logic                    hs_o,
    output logic                    vs_o,
    output logic                    line_end_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Counters keep at least 4 bits so the checkerboard can always use bit 3
    localparam int HW      = $clog2(H_TOTAL) < 4 ? 4 : $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL) < 4 ? 4 : $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = BAR_W > 1 ? $clog2(BAR_W) : 1;

    state_e                  state, state_n;
    logic [1:0]              pat_q, pat;
    logic [HW-1:0]           hcnt;
    logic [VW-1:0]           vcnt;
    logic [BW-1:0]           bar_cnt;
    logic [2:0]              bar_idx;
    logic [3*COLORDEPTH-1:0] rgb;
    logic                    h_last, v_last, bar_last, run, dv, hs, vs;

    assign h_last   = hcnt == HW'(H_TOTAL - 1);
    assign v_last   = vcnt == VW'(V_TOTAL - 1);
    assign bar_last = bar_cnt == BW'(BAR_W - 1);
    assign run      = state != S_IDLE;
    assign dv       = hcnt < HW'(H_ACTIVE) && vcnt < VW'(V_ACTIVE);
    assign hs       = hcnt >= HW'(H_ACTIVE + H_FP) && hcnt < HW'(H_ACTIVE + H_FP + H_SYNC);
    assign vs       = vcnt >= VW'(V_ACTIVE + V_FP) && vcnt < VW'(V_ACTIVE + V_FP + V_SYNC);
    // The pattern input only matters at the top-left pixel; elsewhere the frame's latched value is used
    assign pat      = (hcnt == '0 && vcnt == '0) ? pattern_sel_i : pat_q;

    always_comb
        state_n = state == S_IDLE ? (en_i ? S_RUN : S_IDLE) :
                  en_i            ? S_RUN :
                  h_last && v_last ? S_IDLE : S_DRAIN;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hcnt    <= '0;
            vcnt    <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            pat_q   <= 2'(PAT_BARS);
        end else begin
            pat_q <= pat;
            if (run) begin
                hcnt    <= h_last ? '0 : hcnt + 1'b1;
                vcnt    <= !h_last ? vcnt : v_last ? '0 : vcnt + 1'b1;
                bar_cnt <= (h_last || bar_last) ? '0 : bar_cnt + 1'b1;
                bar_idx <= h_last ? '0 : bar_last ? bar_idx + 3'd1 : bar_idx;
            end
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rgb_o      <= '0;
            dv_o       <= 1'b0;
            hs_o       <= 1'b0;
            vs_o       <= 1'b0;
            line_end_o <= 1'b0;
        end else begin
            rgb_o      <= run ? rgb : '0;
            dv_o       <= run && dv;
            hs_o       <= run && hs;
            vs_o       <= run && vs;
            line_end_o <= run && dv && hcnt == HW'(H_ACTIVE - 1);
        end

    vid_pattern_gen #(
        .COLORDEPTH(COLORDEPTH),
        .HW        (HW),
        .VW        (VW),
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE)
    ) u_pattern (
        .pattern(pat),
        .hcnt   (hcnt),
        .vcnt   (vcnt),
        .bar_idx(bar_idx),
        .rgb    (rgb)
    );

endmodule

// File: tb/tb_vid_timing_gen.sv
// tb_vid_timing_gen: directed checks of timing, patterns, drain and reset on a 14x7 raster
module tb_vid_timing_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic [1:0]  pattern_sel_i = 2'd0;
    logic [23:0] rgb_o;
    logic        dv_o, hs_o, vs_o, line_end_o;
    logic [27:0] obs;
    int          n_cmp = 0;
    int          n_err = 0;

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    vid_timing_gen #(
        .COLORDEPTH(8),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_i),
        .pattern_sel_i(pattern_sel_i),
        .rgb_o        (rgb_o),
        .dv_o         (dv_o),
        .hs_o         (hs_o),
        .vs_o         (vs_o),
        .line_end_o   (line_end_o)
    );

    always #5 clk = ~clk;

    assign obs = {dv_o, hs_o, vs_o, line_end_o, rgb_o};

    // Expected {dv, hs, vs, line_end, rgb} for frame cycle c of a running raster
    function automatic logic [27:0] expect_px(input logic [1:0] pat, input int c);
        int          h = c % 14;
        int          v = (c / 14) % 7;
        logic        dv = h < 8 && v < 4;
        logic [23:0] px;
        px = pat == 2'd0 ? BARS[h % 8] :
             pat == 2'd1 ? {3{8'(h)}} :
             pat == 2'd2 ? ((((h >> 3) ^ (v >> 3)) & 1) != 0 ? 24'h000000 : 24'hFFFFFF) :
                           24'hFFFFFF;
        return {dv, h >= 10 && h < 12, v == 5, dv && h == 7, dv ? px : 24'h0};
    endfunction

    // Leaves the bench one negedge before pixel 0 appears
    task automatic restart(input logic [1:0] pat);
        rst = 1'b1;
        en_i = 1'b0;
        pattern_sel_i = pat;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        en_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en_i = 1'b1;
        pattern_sel_i = 2'd1;
        repeat (10) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== 28'h0) begin
                n_err++;
                $display("FAIL reset_hold got %h want %h", obs, 28'h0);
            end
        end
        en_i = 1'b0;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== 28'h0) begin
                n_err++;
                $display("FAIL idle got %h want %h", obs, 28'h0);
            end
        end
    endtask

    task automatic test_ramp();
        int   vs_len = 0;
        int   rises[$];
        logic vs_prev = 1'b0;
        restart(2'd1);
        for (int c = 0; c < 196; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== expect_px(2'd1, c)) begin
                n_err++;
                $display("FAIL ramp c=%0d got %h want %h", c, obs, expect_px(2'd1, c));
            end
            if (vs_o && c < 98) vs_len++;
            if (vs_o && !vs_prev) rises.push_back(c);
            vs_prev = vs_o;
        end
        n_cmp++;
        if (vs_len != 14) begin
            n_err++;
            $display("FAIL vs_width got %0d want %0d", vs_len, 14);
        end
        n_cmp++;
        if (rises.size() != 2 || rises[0] != 70 || rises[1] - rises[0] != 98) begin
            n_err++;
            $display("FAIL frame_period got %0d rises want 2 rises at 70 and 168", rises.size());
        end
    endtask

    task automatic test_patterns();
        for (int p = 0; p < 4; p++) begin
            restart(2'(p));
            for (int c = 0; c < 98; c++) begin
                @(negedge clk);
                n_cmp++;
                if (obs !== expect_px(2'(p), c)) begin
                    n_err++;
                    $display("FAIL pattern%0d c=%0d got %h want %h", p, c, obs, expect_px(2'(p), c));
                end
            end
        end
    endtask

    task automatic test_pattern_change();
        restart(2'd1);
        for (int c = 0; c < 196; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== expect_px(c < 98 ? 2'd1 : 2'd0, c)) begin
                n_err++;
                $display("FAIL pat_change c=%0d got %h want %h", c, obs, expect_px(c < 98 ? 2'd1 : 2'd0, c));
            end
            if (c == 28) pattern_sel_i = 2'd0;
        end
    endtask

    task automatic test_drain();
        restart(2'd1);
        for (int c = 0; c < 112; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== (c < 98 ? expect_px(2'd1, c) : 28'h0)) begin
                n_err++;
                $display("FAIL drain c=%0d got %h want %h", c, obs, c < 98 ? expect_px(2'd1, c) : 28'h0);
            end
            if (c == 14) en_i = 1'b0;
        end
        en_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== 28'h0) begin
            n_err++;
            $display("FAIL restart_gap got %h want %h", obs, 28'h0);
        end
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== expect_px(2'd1, c)) begin
                n_err++;
                $display("FAIL restart c=%0d got %h want %h", c, obs, expect_px(2'd1, c));
            end
        end
    endtask

    task automatic test_back_to_back();
        restart(2'd1);
        for (int c = 0; c < 196; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== expect_px(2'd1, c)) begin
                n_err++;
                $display("FAIL b2b c=%0d got %h want %h", c, obs, expect_px(2'd1, c));
            end
            if (c == 14) en_i = 1'b0;
            if (c == 30) en_i = 1'b1;
        end
    endtask

    task automatic test_mid_reset();
        restart(2'd0);
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== expect_px(2'd0, c)) begin
                n_err++;
                $display("FAIL pre_reset c=%0d got %h want %h", c, obs, expect_px(2'd0, c));
            end
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 28'h0) begin
            n_err++;
            $display("FAIL async_reset got %h want %h", obs, 28'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs !== 28'h0) begin
            n_err++;
            $display("FAIL first_edge got %h want %h", obs, 28'h0);
        end
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== expect_px(2'd0, c)) begin
                n_err++;
                $display("FAIL post_reset c=%0d got %h want %h", c, obs, expect_px(2'd0, c));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_patterns();
        test_pattern_change();
        test_drain();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
